decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 26 ++
 rtl/decode_stage_register_file.sv | 42 ++++
 rtl/decode_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcodes, ALU op codes
// and the packed ID/EX control bundle.
package decode_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/decode_stage_register_file.sv
// Register file: two combinational read ports with write-first bypass, one write port.
// Ports: clk, reset, rs_addr/rt_addr -> rs_data/rt_data, wr_en/wr_addr/wr_data.
module register_file #(
  parameter int DATA_W = 32,
  parameter int REG_CNT = 32,
  localparam int REG_AW = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [REG_CNT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else if (wr_en && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // r0 is hard zero; a same-cycle write wins over the stored value
  always_comb begin
    rs_data = regs[rs_addr];
    if (rs_addr == '0) rs_data = '0;
    else if (wr_en && wr_addr == rs_addr) rs_data = wr_data;
  end

  always_comb begin
    rt_data = regs[rt_addr];
    if (rt_addr == '0) rt_data = '0;
    else if (wr_en && wr_addr == rt_addr) rt_data = wr_data;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: opcode decode, register read, load-use stall, ID/EX register.
// Ports: clk/reset, instr_in/valid, wb_*, flush -> ex_* bundle, stall, illegal_instr.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_CNT = 32,
  localparam int REG_AW = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_in,
  input  logic              instr_valid,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              flush,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_branch,
  output logic              ex_mem_write,
  output logic              ex_mem_read,
  output logic              ex_alu_src,
  output logic              ex_reg_dst,
  output logic [1:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_branch_imm,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic              stall,
  output logic              illegal_instr
);

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] imm, rs_data, rt_data;
  ctrl_t             ctrl, ex_ctrl;
  logic              legal, reads_rt, load;

  assign opcode = instr_in[31:26];
  assign rs = instr_in[21 +: REG_AW];
  assign rt = instr_in[16 +: REG_AW];
  assign rd = instr_in[11 +: REG_AW];
  assign imm = {{(DATA_W-16){instr_in[15]}}, instr_in[15:0]};

  register_file #(
    .DATA_W(DATA_W),
    .REG_CNT(REG_CNT)
  ) rf_main (
    .clk(clk),
    .reset(reset),
    .rs_addr(rs),
    .rt_addr(rt),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .wr_en(wb_reg_write),
    .wr_addr(wb_write_reg),
    .wr_data(wb_write_data)
  );

  always_comb begin
    ctrl = '0;
    legal = 1'b1;
    reads_rt = 1'b0;
    unique case (1'b1)
      (opcode == OP_RTYPE): begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst = 1'b1;
        ctrl.alu_op = ALU_FUNCT;
        reads_rt = 1'b1;
      end
      (opcode == OP_LW): begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.alu_op = ALU_ADD;
      end
      (opcode == OP_SW): begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.alu_op = ALU_ADD;
        reads_rt = 1'b1;
      end
      (opcode == OP_BEQ): begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
        reads_rt = 1'b1;
      end
      (opcode == OP_ADDI): begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.alu_op = ALU_ADD;
      end
      default: legal = 1'b0;
    endcase
  end

  // load in EX whose result the current instruction needs
  assign stall = instr_valid && !flush
    && ex_valid && ex_ctrl.mem_read && ex_rt != '0
    && (ex_rt == rs || (reads_rt && ex_rt == rt));

  assign load = instr_valid && !flush && !stall && legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_ctrl <= '0;
      ex_branch_imm <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_rs <= '0;
      ex_rt <= '0;
      ex_rd <= '0;
      illegal_instr <= 1'b0;
    end else begin
      ex_valid <= load;
      ex_ctrl <= load ? ctrl : '0;
      ex_branch_imm <= load ? imm : '0;
      ex_rs_data <= load ? rs_data : '0;
      ex_rt_data <= load ? rt_data : '0;
      ex_rs <= load ? rs : '0;
      ex_rt <= load ? rt : '0;
      ex_rd <= load ? rd : '0;
      if (instr_valid && !flush && !legal) illegal_instr <= 1'b1;
    end
  end

  assign ex_reg_write = ex_ctrl.reg_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_branch = ex_ctrl.branch;
  assign ex_mem_write = ex_ctrl.mem_write;
  assign ex_mem_read = ex_ctrl.mem_read;
  assign ex_alu_src = ex_ctrl.alu_src;
  assign ex_reg_dst = ex_ctrl.reg_dst;
  assign ex_alu_op = ex_ctrl.alu_op;

endmodule
